// File: rtl/song_recorder.sv
// rtl/song_recorder.sv - records a played melody into song RAM as {note, duration} entries
//
// Purpose: measures key holds and the gaps between keys in beats and writes one
// {note, duration} entry per note or rest, then an end-of-song marker {0,0}.
// Ports:
//   clk, reset (async, active-low)
//   record_button  one-cycle pulse, starts/stops recording
//   song           target slot, latched at record start
//   key_down       key held level
//   key_note       note of the held key
//   beat           one-cycle time base pulse
//   wr_en/wr_addr/wr_data  registered song RAM write port
//   recording      high while capturing (START, NOTE, REST)
//   song_full      recording stopped by running out of slot space
//   note_count     data entries written in the current/last recording
`timescale 1ns/1ps
module song_recorder #(
  parameter int NOTES_PER_SONG = 32,
  parameter int ADDR_BITS      = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 record_button,
  input  logic [1:0]           song,
  input  logic                 key_down,
  input  logic [5:0]           key_note,
  input  logic                 beat,
  output logic                 wr_en,
  output logic [ADDR_BITS+1:0] wr_addr,
  output logic [11:0]          wr_data,
  output logic                 recording,
  output logic                 song_full,
  output logic [ADDR_BITS:0]   note_count
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_NOTE, S_REST, S_END} state_t;

  // Last index a data entry may use; the slot's final entry is kept for the terminator.
  localparam logic [ADDR_BITS-1:0] LAST_DATA = ADDR_BITS'(NOTES_PER_SONG - 2);
  localparam logic [5:0]           DUR_MAX   = 6'd63;

  state_t                 state;
  state_t                 nxt_state;
  logic [1:0]             song_l;
  logic [ADDR_BITS-1:0]   index;
  logic [5:0]             cur_note;
  logic [5:0]             nxt_note;
  logic [5:0]             dur;
  logic [5:0]             nxt_dur;
  logic                   key_down_q;
  logic [5:0]             key_note_q;

  logic [5:0]             d_next;
  logic [5:0]             dur_min1;
  logic                   key_rise;
  logic                   key_fall;
  logic                   note_chg;
  logic                   data_wr;
  logic                   term_wr;
  logic [11:0]            data_val;

  // A beat in the same cycle as any event is counted before the entry is written.
  assign d_next   = dur + {5'd0, beat};
  assign dur_min1 = (d_next == 6'd0) ? 6'd1 : d_next;
  assign key_rise = key_down & ~key_down_q;
  assign key_fall = ~key_down & key_down_q;
  assign note_chg = key_down & key_down_q & (key_note != key_note_q);

  always_comb begin
    nxt_state = state;
    nxt_note  = cur_note;
    nxt_dur   = dur;
    data_wr   = 1'b0;
    term_wr   = 1'b0;
    data_val  = 12'd0;
    case (state)
      S_IDLE: begin
        nxt_dur = 6'd0;
        if (record_button) nxt_state = S_START;
      end
      S_START: begin
        if (record_button) begin
          term_wr   = 1'b1;
          nxt_state = S_IDLE;
        end else if (key_down) begin
          nxt_note  = key_note;
          nxt_dur   = 6'd0;
          nxt_state = S_NOTE;
        end
      end
      S_NOTE: begin
        nxt_dur = d_next;
        // Stop takes priority over key edges; the held note is flushed as-is.
        if (record_button) begin
          data_wr   = 1'b1;
          data_val  = {cur_note, dur_min1};
          nxt_state = S_END;
        end else if (key_fall) begin
          data_wr   = 1'b1;
          data_val  = {cur_note, dur_min1};
          nxt_dur   = 6'd0;
          nxt_state = S_REST;
        end else if (note_chg) begin
          data_wr  = 1'b1;
          data_val = {cur_note, dur_min1};
          nxt_note = key_note;
          nxt_dur  = 6'd0;
        end else if (d_next == DUR_MAX) begin
          data_wr  = 1'b1;
          data_val = {cur_note, DUR_MAX};
          nxt_dur  = 6'd0;
        end
      end
      S_REST: begin
        nxt_dur = d_next;
        if (record_button) begin
          if (d_next != 6'd0) begin
            data_wr   = 1'b1;
            data_val  = {6'd0, d_next};
            nxt_state = S_END;
          end else begin
            term_wr   = 1'b1;
            nxt_state = S_IDLE;
          end
        end else if (key_rise) begin
          // Zero-length gaps between keys are not recorded as rests.
          if (d_next != 6'd0) begin
            data_wr  = 1'b1;
            data_val = {6'd0, d_next};
          end
          nxt_note  = key_note;
          nxt_dur   = 6'd0;
          nxt_state = S_NOTE;
        end else if (d_next == DUR_MAX) begin
          data_wr  = 1'b1;
          data_val = {6'd0, DUR_MAX};
          nxt_dur  = 6'd0;
        end
      end
      S_END: begin
        term_wr   = 1'b1;
        nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
    // Slot space exhausted: finish with the terminator in the last entry.
    if (data_wr && (index == LAST_DATA)) nxt_state = S_END;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      song_l     <= 2'd0;
      index      <= '0;
      cur_note   <= 6'd0;
      dur        <= 6'd0;
      key_down_q <= 1'b0;
      key_note_q <= 6'd0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 12'd0;
      recording  <= 1'b0;
      song_full  <= 1'b0;
      note_count <= '0;
    end else begin
      state      <= nxt_state;
      cur_note   <= nxt_note;
      dur        <= nxt_dur;
      key_down_q <= key_down;
      key_note_q <= key_note;
      wr_en      <= data_wr | term_wr;
      recording  <= (nxt_state == S_START) || (nxt_state == S_NOTE) || (nxt_state == S_REST);
      if (data_wr || term_wr) begin
        wr_addr <= {song_l, index};
        wr_data <= data_wr ? data_val : 12'd0;
      end
      if ((state == S_IDLE) && record_button) begin
        song_l     <= song;
        index      <= '0;
        note_count <= '0;
        song_full  <= 1'b0;
      end
      if (data_wr) begin
        index      <= index + ADDR_BITS'(1);
        note_count <= note_count + (ADDR_BITS+1)'(1);
        if (index == LAST_DATA) song_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_song_recorder.sv
// tb/tb_song_recorder.sv - self-checking bench for song_recorder
`timescale 1ns/1ps
module tb_song_recorder;

  localparam int NPS = 32;
  localparam int AB  = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        record_button = 1'b0;
  logic [1:0]  song = 2'd0;
  logic        key_down = 1'b0;
  logic [5:0]  key_note = 6'd0;
  logic        beat = 1'b0;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [11:0] wr_data;
  logic        recording;
  logic        song_full;
  logic [5:0]  note_count;

  song_recorder #(.NOTES_PER_SONG(NPS), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .record_button(record_button), .song(song),
    .key_down(key_down), .key_note(key_note), .beat(beat),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .recording(recording), .song_full(song_full), .note_count(note_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [18:0] wlog[$];

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_START = 1, M_NOTE = 2, M_REST = 3, M_END = 4;
  int          m_mode = M_IDLE;
  int          m_note = 0;
  int          m_seg = 0;      // beats since the current note/rest began (not split)
  logic [1:0]  m_slot = 2'd0;
  int          m_idx = 0;
  int          m_cnt = 0;
  bit          m_full = 1'b0;
  bit          m_cap = 1'b0;
  bit          m_pkd = 1'b0;
  int          m_pkn = 0;
  bit          exp_wr_en = 1'b0;
  logic [6:0]  exp_addr = 7'd0;
  logic [11:0] exp_data = 12'd0;
  bit          exp_rec = 1'b0;

  task automatic model_reset();
    m_mode = M_IDLE; m_note = 0; m_seg = 0; m_slot = 2'd0; m_idx = 0; m_cnt = 0;
    m_full = 1'b0; m_pkd = 1'b0; m_pkn = 0; exp_wr_en = 1'b0; exp_rec = 1'b0;
  endtask

  task automatic m_emit(input int n, input int d);
    exp_wr_en = 1'b1;
    exp_addr  = {m_slot, 5'(m_idx)};
    exp_data  = {6'(n), 6'(d)};
    if (m_idx == NPS - 2) begin
      m_full = 1'b1;
      m_cap  = 1'b1;
    end
    m_idx++;
    m_cnt++;
  endtask

  task automatic m_term();
    exp_wr_en = 1'b1;
    exp_addr  = {m_slot, 5'(m_idx)};
    exp_data  = 12'd0;
  endtask

  task automatic model_step();
    bit rise, fall, chg, sat_now, ending, wrote;
    int wn;
    rise = key_down && !m_pkd;
    fall = !key_down && m_pkd;
    chg  = key_down && m_pkd && (int'(key_note) != m_pkn);
    exp_wr_en = 1'b0;
    m_cap = 1'b0;
    wrote = 1'b0;
    case (m_mode)
      M_IDLE: if (record_button) begin
        m_slot = song; m_idx = 0; m_cnt = 0; m_full = 1'b0; m_mode = M_START;
      end
      M_START: begin
        if (record_button) begin
          m_term(); m_mode = M_IDLE;
        end else if (key_down) begin
          m_note = key_note; m_seg = 0; m_mode = M_NOTE;
        end
      end
      M_NOTE, M_REST: begin
        wn = (m_mode == M_NOTE) ? m_note : 0;
        m_seg += int'(beat);
        sat_now = beat && (m_seg % 63 == 0);
        ending  = record_button || ((m_mode == M_NOTE) ? (fall || chg) : rise);
        if (sat_now) begin
          m_emit(wn, 63); wrote = 1'b1;
        end else if (ending && (m_seg % 63 != 0)) begin
          m_emit(wn, m_seg % 63); wrote = 1'b1;
        end else if (ending && m_mode == M_NOTE) begin
          m_emit(wn, 1); wrote = 1'b1;
        end
        if (m_cap) m_mode = M_END;
        else if (record_button) begin
          if (wrote) m_mode = M_END;
          else begin m_term(); m_mode = M_IDLE; end
        end else if (ending) begin
          if (m_mode == M_NOTE && fall) m_mode = M_REST;
          else begin m_mode = M_NOTE; m_note = key_note; end
          m_seg = 0;
        end
      end
      M_END: begin
        m_term(); m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
    exp_rec = (m_mode == M_START) || (m_mode == M_NOTE) || (m_mode == M_REST);
    m_pkd = key_down;
    m_pkn = key_note;
  endtask

  always @(posedge clk) if (reset) model_step();
  always @(negedge reset) model_reset();

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset) begin
      tests++;
      if (wr_en !== exp_wr_en || recording !== exp_rec || song_full !== m_full ||
          int'(note_count) != m_cnt ||
          (exp_wr_en && (wr_addr !== exp_addr || wr_data !== exp_data))) begin
        fails++;
        $display("FAIL cycle_check t=%0t got wr_en=%b addr=%h data=%h rec=%b full=%b cnt=%0d need wr_en=%b addr=%h data=%h rec=%b full=%b cnt=%0d",
                 $time, wr_en, wr_addr, wr_data, recording, song_full, note_count,
                 exp_wr_en, exp_addr, exp_data, exp_rec, m_full, m_cnt);
      end
      if (wr_en) wlog.push_back({wr_addr, wr_data});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s got=%h need=%h", name, act, expv);
    end
  endtask

  task automatic step(input bit kd, input int kn, input bit b, input bit rb);
    key_down = kd; key_note = 6'(kn); beat = b; record_button = rb;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    bit kd_r;
    int kn_r;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_wr_en", 32'(wr_en), 0);
    chk("reset_recording", 32'(recording), 0);
    chk("reset_song_full", 32'(song_full), 0);
    chk("reset_note_count", 32'(note_count), 0);
    chk("reset_wr_addr_data", {13'd0, wr_addr, wr_data}, 0);
    reset = 1'b1;
    idle(2);

    // Basic
    wlog.delete(); song = 2'd2;
    step(0, 0, 0, 1);
    step(1, 10, 0, 0);
    repeat (3) step(1, 10, 1, 0);
    step(0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0);
    step(1, 12, 0, 0);
    step(1, 12, 1, 0);
    step(1, 12, 0, 1);
    idle(3);
    chk("basic_nwrites", wlog.size(), 4);
    chk("basic_w0", 32'(wlog[0]), {13'd0, 7'h40, 12'h283});
    chk("basic_w1", 32'(wlog[1]), {13'd0, 7'h41, 12'h002});
    chk("basic_w2", 32'(wlog[2]), {13'd0, 7'h42, 12'h301});
    chk("basic_w3", 32'(wlog[3]), {13'd0, 7'h43, 12'h000});
    chk("basic_count", 32'(note_count), 3);
    chk("basic_rec", 32'(recording), 0);

    // Short press
    wlog.delete(); song = 2'd1;
    step(0, 0, 0, 1);
    step(1, 5, 0, 0);
    step(1, 5, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    idle(3);
    chk("short_nwrites", wlog.size(), 2);
    chk("short_w0", 32'(wlog[0]), {13'd0, 7'h20, 12'h141});
    chk("short_w1", 32'(wlog[1]), {13'd0, 7'h21, 12'h000});

    // Saturation
    wlog.delete(); song = 2'd0;
    step(0, 0, 0, 1);
    step(1, 7, 0, 0);
    repeat (70) step(1, 7, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    idle(3);
    chk("sat_nwrites", wlog.size(), 3);
    chk("sat_w0", 32'(wlog[0][11:0]), 32'h1FF);
    chk("sat_w1", 32'(wlog[1][11:0]), 32'h1C7);
    chk("sat_w2", 32'(wlog[2][11:0]), 32'h000);

    // Capacity
    wlog.delete(); song = 2'd0;
    step(0, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      kn_r = $urandom_range(1, 63);
      step(1, kn_r, 0, 0);
      step(1, kn_r, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
    end
    idle(3);
    chk("cap_nwrites", wlog.size(), 32);
    chk("cap_idx30", 32'(wlog[30][18:12]), 32'h1E);
    chk("cap_term", 32'(wlog[31]), {13'd0, 7'h1F, 12'h000});
    chk("cap_full", 32'(song_full), 1);
    chk("cap_count", 32'(note_count), 31);
    chk("cap_rec", 32'(recording), 0);

    // Simultaneous events
    wlog.delete(); song = 2'd3;
    step(0, 0, 0, 1);
    step(1, 9, 0, 0);
    repeat (2) step(1, 9, 1, 0);
    step(0, 0, 1, 0);
    step(1, 20, 0, 0);
    step(1, 20, 1, 0);
    step(1, 21, 0, 1);
    idle(3);
    chk("simul_nwrites", wlog.size(), 3);
    chk("simul_w0", 32'(wlog[0]), {13'd0, 7'h60, 12'h243});
    chk("simul_w1", 32'(wlog[1]), {13'd0, 7'h61, 12'h501});
    chk("simul_w2", 32'(wlog[2]), {13'd0, 7'h62, 12'h000});
    chk("simul_song_full_cleared", 32'(song_full), 0);

    // Asynchronous reset mid-NOTE
    song = 2'd3;
    step(0, 0, 0, 1);
    step(1, 4, 0, 0);
    step(1, 4, 1, 0);
    step(1, 5, 0, 0);
    step(1, 5, 1, 0);
    chk("pre_reset_count", 32'(note_count), 1);
    #3 reset = 1'b0;
    #1;
    chk("async_wr_en", 32'(wr_en), 0);
    chk("async_rec", 32'(recording), 0);
    chk("async_full", 32'(song_full), 0);
    chk("async_count", 32'(note_count), 0);
    key_down = 1'b0; key_note = 6'd0; beat = 1'b0; record_button = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(1);
    wlog.delete();
    step(0, 0, 0, 1);
    step(1, 6, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    idle(3);
    chk("restart_nwrites", wlog.size(), 2);
    chk("restart_w0", 32'(wlog[0]), {13'd0, 7'h60, 12'h181});
    chk("restart_w1", 32'(wlog[1]), {13'd0, 7'h61, 12'h000});

    // Randomized traffic, checked every cycle against the model
    kd_r = 1'b0;
    kn_r = 1;
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(0, 99) < 2) kd_r = !kd_r;
      if (kd_r && $urandom_range(0, 39) == 0) kn_r = $urandom_range(1, 63);
      song = 2'($urandom_range(0, 3));
      step(kd_r, kd_r ? kn_r : $urandom_range(0, 63),
           $urandom_range(0, 1) == 0, $urandom_range(0, 79) == 0);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
